qupdate_ctrl: RTL

QUPDATE_CTRL -- requirements
Module: qupdate_ctrl

---
 rtl/qupdate_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/qupdate_ctrl.sv
// Q-learning table update controller: Q(s,a) += alpha*(r + gamma*max Q(s',.) - Q(s,a)).
// Optional greedy-action output enabled by defining QUPD_GREEDY_OUT_EN.
module qupdate_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ACTION_W    = 2,
    parameter int ALPHA_SHIFT = 1,
    parameter int GAMMA_SHIFT = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [ADDR_WIDTH-ACTION_W-1:0] i_state,
    input  logic [ACTION_W-1:0]            i_action,
    input  logic [ADDR_WIDTH-ACTION_W-1:0] i_next_state,
    input  logic [DATA_WIDTH-1:0]          i_reward,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr_r,
    input  logic [DATA_WIDTH-1:0]          i_mem_data,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr_w,
    output logic                           o_mem_we,
    output logic [DATA_WIDTH-1:0]          o_mem_data,
`ifdef QUPD_GREEDY_OUT_EN
    output logic [ACTION_W-1:0]            o_best_action,
`endif
    output logic                           o_done
);

    localparam int SW = ADDR_WIDTH - ACTION_W;
    localparam int CW = DATA_WIDTH + 2;
    localparam logic signed [CW-1:0] MAXV = $signed({2'b00, {DATA_WIDTH{1'b1}}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_CALC,
        S_WRITE
    } state_t;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [SW-1:0]         r_s;
    logic [ACTION_W-1:0]   r_a;
    logic [SW-1:0]         r_sp;
    logic [DATA_WIDTH-1:0] r_r;
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_max;
    logic                  w_sample;

`ifdef QUPD_GREEDY_OUT_EN
    logic [ACTION_W-1:0]   r_best;
    logic [2:0]            w_idx;
    assign w_idx = r_cnt - 3'd2;
`endif

    logic signed [CW-1:0]  w_max;
    logic signed [CW-1:0]  w_max_sh;
    logic signed [CW-1:0]  w_g;
    logic signed [CW-1:0]  w_sum;
    logic signed [CW-1:0]  w_tgt;
    logic signed [CW-1:0]  w_qx;
    logic signed [CW-1:0]  w_diff;
    logic signed [CW-1:0]  w_raw;
    logic [DATA_WIDTH-1:0] w_new;

    always_comb begin
        w_max    = $signed({2'b00, r_max});
        w_max_sh = $signed({2'b00, r_max >> GAMMA_SHIFT});
        w_g      = w_max - w_max_sh;
        w_sum    = $signed({2'b00, r_r}) + w_g;
        w_tgt    = (w_sum > MAXV) ? MAXV : w_sum;
        w_qx     = $signed({2'b00, r_q});
        w_diff   = w_tgt - w_qx;
        w_raw    = w_qx + (w_diff >>> ALPHA_SHIFT);
        if (w_raw[CW-1])
            w_new = '0;
        else if (w_raw > MAXV)
            w_new = {DATA_WIDTH{1'b1}};
        else
            w_new = w_raw[DATA_WIDTH-1:0];
    end

    // s' data arrives two cycles behind the counter: cnt 2..5 carry actions 0..3
    assign w_sample = (r_state == S_DRAIN) ||
                      ((r_state == S_READ) && (r_cnt >= 3'd2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_s          <= '0;
            r_a          <= '0;
            r_sp         <= '0;
            r_r          <= '0;
            r_q          <= '0;
            r_max        <= '0;
            o_ready      <= 1'b1;
            o_mem_addr_r <= '0;
            o_mem_addr_w <= '0;
            o_mem_we     <= 1'b0;
            o_mem_data   <= '0;
            o_done       <= 1'b0;
`ifdef QUPD_GREEDY_OUT_EN
            r_best        <= '0;
            o_best_action <= '0;
`endif
        end else begin
            o_mem_we <= 1'b0;
            o_done   <= 1'b0;

            if (w_sample && (i_mem_data > r_max)) begin
                r_max <= i_mem_data;
`ifdef QUPD_GREEDY_OUT_EN
                r_best <= ACTION_W'(w_idx);
`endif
            end

            unique case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_s          <= i_state;
                        r_a          <= i_action;
                        r_sp         <= i_next_state;
                        r_r          <= i_reward;
                        r_cnt        <= '0;
                        r_max        <= '0;
`ifdef QUPD_GREEDY_OUT_EN
                        r_best       <= '0;
`endif
                        o_mem_addr_r <= {i_state, i_action};
                        o_ready      <= 1'b0;
                        r_state      <= S_READ;
                    end
                end
                S_READ: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd1)
                        r_q <= i_mem_data;
                    if (r_cnt < 3'd4)
                        o_mem_addr_r <= {r_sp, ACTION_W'(r_cnt)};
                    else
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    o_mem_we     <= 1'b1;
                    o_done       <= 1'b1;
                    o_mem_addr_w <= {r_s, r_a};
                    o_mem_data   <= w_new;
`ifdef QUPD_GREEDY_OUT_EN
                    o_best_action <= r_best;
`endif
                    r_state      <= S_WRITE;
                end
                S_WRITE: begin
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
